nios_system_hpi_bus_ctrl: RTL and testbench
===========================================

// Module: nios_system_hpi_bus_ctrl
// PURPOSE
//  Hardware HPI master for the EZ-OTG (CY7C67200) host port interface; replaces software bit-banging of the PIO data/addr/strobe ports.
//  Avalon-MM slave on the Nios II side; drives the timed HPI cycle on the chip pins.
//  Stalls the CPU with waitrequest until the HPI cycle completes.
//  Optionally synchronises the chip interrupt onto an Avalon irq.
// PARAMETERS
//  SETUP_CYC    1  cycles cs_n/addr (and write data) valid before strobe; 0 = no setup
//  STROBE_CYC   4  cycles rd_n/wr_n held low; legal range 1..15
//  HOLD_CYC     1  cycles cs_n/addr/data held after strobe rises; 0 = no hold
//  RECOVER_CYC  2  idle cycles, cs_n high, before next request is accepted; 0 = none
// PORTS
//  clk             in   1   system clock
//  reset_n         in   1   asynchronous active-low reset
//  avs_address     in   2   HPI register: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
//  avs_chipselect  in   1   slave select
//  avs_read        in   1   read request
//  avs_write       in   1   write request
//  avs_writedata   in   32  write data; only [15:0] is used
//  avs_readdata    out  32  read data, zero-extended from 16 bits
//  avs_waitrequest out  1   stall; low for exactly one cycle when a transfer completes
//  otg_addr        out  2   HPI address pins
//  otg_data_out    out  16  data to chip
//  otg_data_oe     out  1   tri-state enable for otg_data_out; top level builds the inout
//  otg_data_in     in   16  data from chip
//  otg_cs_n        out  1   chip select, active low
//  otg_rd_n        out  1   read strobe, active low
//  otg_wr_n        out  1   write strobe, active low
//  otg_int         in   1   raw chip interrupt, asynchronous (used only with HPI_IRQ_SYNC_EN)
//  irq             out  1   Avalon interrupt (present only with HPI_IRQ_SYNC_EN)
// BEHAVIOUR
//  - Reset values: cs_n=rd_n=wr_n=1, oe=0, otg_addr=0, otg_data_out=0, avs_readdata=0, irq=0; state IDLE.
//  - avs_waitrequest = (state != DONE), so it is 1 out of reset and whenever idle.
//  - FSM: IDLE -> SETUP -> STROBE -> HOLD -> DONE -> RECOVER -> IDLE.
//  - Any state whose cycle count is 0 is skipped. A down-counter of 4 bits is loaded on entry to each state.
//  - IDLE: accept when chipselect & (read|write).
//    - Capture address, direction and writedata[15:0] into registers.
//    - Read and write asserted together: treat as a write.
//  - SETUP: cs_n=0, addr driven. For writes, oe=1 and data driven.
//  - STROBE: rd_n or wr_n =0. On the clock edge ending the last STROBE cycle, register otg_data_in[15:0] into avs_readdata.
//  - HOLD: strobes=1; cs_n, addr, data and oe unchanged.
//  - DONE: one cycle; cs_n=1, oe=0, waitrequest=0, readdata valid. avs_readdata holds until the next read completes.
//  - RECOVER: cs_n=1. New requests are ignored until IDLE.
//  - Latency (defaults): request seen at cycle 0 -> waitrequest low at cycle 1+SETUP+STROBE+HOLD = 7.
//  - Back-to-back spacing (defaults): 1+S+T+H+1+R = 10 cycles per transfer.
//  - Request dropped by the master mid-cycle: the HPI cycle still completes.
//  - Reset mid-transfer: all strobes and cs_n go high and oe goes low immediately (asynchronously). No partial cycle resumes.
//  - Strobes and cs_n are driven from flops only, so the pins are glitch-free.
// CONFIGURATION
//  - HPI_IRQ_SYNC_EN defined:
//    - otg_int passes a 2-flop synchroniser; irq = synchronised level.
//    - Reading STATUS (addr 3) performs a normal HPI read; no local status register.
//  - Not defined: the otg_int and irq ports are absent; no synchroniser logic.
// STRUCTURE
//  - Package nios_hpi_pkg holds:
//    - state encoding localparams (IDLE, SETUP, STROBE, HOLD, DONE, RECOVER);
//    - HPI register offsets (HPI_DATA=0, HPI_MAILBOX=1, HPI_ADDRESS=2, HPI_STATUS=3);
//    - counter width CNT_W=4.
//  - Sub-module nios_hpi_sync: 2-flop synchroniser with async reset to 0; instantiated only under HPI_IRQ_SYNC_EN.
// TESTING
//  - Write addr 2, data 0x1234ABCD:
//    - cs_n low at cycles 1..6; wr_n low at cycles 2..5;
//    - otg_addr=2, otg_data_out=0xABCD, oe=1 at cycles 1..6;
//    - waitrequest low at cycle 7 only.
//  - Read addr 0, chip drives 0xBEEF:
//    - rd_n low for 4 cycles;
//    - readdata=0x0000BEEF when waitrequest falls; oe stays 0 throughout.
//  - Two back-to-back writes: the second cs_n falling edge is exactly 10 cycles after the first.
//  - reset_n pulsed low during the 2nd STROBE cycle:
//    - cs_n, wr_n high and oe=0 immediately;
//    - after release, waitrequest=1 and no strobe occurs until a new request.
//  - read=write=1: a write cycle is performed (wr_n toggles, rd_n stays 1).
//  - HPI_IRQ_SYNC_EN: otg_int 0->1 -> irq rises 2 clocks later.

Source files
------------

// File: rtl/nios_hpi_pkg.sv
// Shared definitions for the EZ-OTG HPI bus controller: state encoding,
// HPI register offsets and the phase-timer width.
package nios_hpi_pkg;

   localparam int CNT_W = 4;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] SETUP   = 3'd1;
   localparam logic [2:0] STROBE  = 3'd2;
   localparam logic [2:0] HOLD    = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;
   localparam logic [2:0] RECOVER = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE    = IDLE,
      S_SETUP   = SETUP,
      S_STROBE  = STROBE,
      S_HOLD    = HOLD,
      S_DONE    = DONE,
      S_RECOVER = RECOVER
   } hpi_state_e;

   localparam logic [1:0] HPI_DATA    = 2'd0;
   localparam logic [1:0] HPI_MAILBOX = 2'd1;
   localparam logic [1:0] HPI_ADDRESS = 2'd2;
   localparam logic [1:0] HPI_STATUS  = 2'd3;

endpackage

// File: rtl/nios_hpi_sync.sv
// Two-flop synchroniser for the asynchronous EZ-OTG interrupt line.
module nios_hpi_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/nios_system_hpi_bus_ctrl.sv
// Avalon-MM slave that runs timed HPI read/write cycles on the CY7C67200 pins.
// Define HPI_IRQ_SYNC_EN to add the otg_int/irq ports and the interrupt synchroniser.
//
// state   | meaning
// IDLE    | waiting for an Avalon read/write
// SETUP   | cs_n low, address (and write data) settling before the strobe
// STROBE  | rd_n or wr_n low; read data captured on the last cycle
// HOLD    | strobe released, cs_n/address/data still held
// DONE    | one cycle with waitrequest low, transfer complete
// RECOVER | cs_n high, new requests ignored
module nios_system_hpi_bus_ctrl
   import nios_hpi_pkg::*;
#(
   parameter int SETUP_CYC   = 1,
   parameter int STROBE_CYC  = 4,
   parameter int HOLD_CYC    = 1,
   parameter int RECOVER_CYC = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  avs_address,
   input  logic        avs_chipselect,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   output logic [31:0] avs_readdata,
   output logic        avs_waitrequest,
   output logic [1:0]  otg_addr,
   output logic [15:0] otg_data_out,
   output logic        otg_data_oe,
   input  logic [15:0] otg_data_in,
   output logic        otg_cs_n,
   output logic        otg_rd_n,
   output logic        otg_wr_n
`ifdef HPI_IRQ_SYNC_EN
   ,
   input  logic        otg_int,
   output logic        irq
`endif
);

   hpi_state_e       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             is_wr, wr_nxt;
   logic             accept, cnt_tc, cyc_active;
   logic             unused_wdata;

   assign unused_wdata    = ^avs_writedata[31:16];
   assign accept          = avs_chipselect && (avs_read || avs_write);
   assign cnt_tc          = (cnt == '0);
   assign avs_waitrequest = (state != S_DONE);

   function automatic logic [CNT_W-1:0] cnt_load(hpi_state_e s);
      case (s)
         S_SETUP:   cnt_load = CNT_W'(SETUP_CYC - 1);
         S_STROBE:  cnt_load = CNT_W'(STROBE_CYC - 1);
         S_HOLD:    cnt_load = CNT_W'(HOLD_CYC - 1);
         S_RECOVER: cnt_load = CNT_W'(RECOVER_CYC - 1);
         default:   cnt_load = '0;
      endcase
   endfunction

   // Zero-length phases are skipped by choosing the successor statically.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (accept) state_nxt = (SETUP_CYC > 0) ? S_SETUP : S_STROBE;
         S_SETUP:   if (cnt_tc) state_nxt = S_STROBE;
         S_STROBE:  if (cnt_tc) state_nxt = (HOLD_CYC > 0) ? S_HOLD : S_DONE;
         S_HOLD:    if (cnt_tc) state_nxt = S_DONE;
         S_DONE:    state_nxt = (RECOVER_CYC > 0) ? S_RECOVER : S_IDLE;
         S_RECOVER: if (cnt_tc) state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase

      if (state_nxt != state) cnt_nxt = cnt_load(state_nxt);
      else if (!cnt_tc)       cnt_nxt = cnt - 1'b1;
      else                    cnt_nxt = cnt;

      wr_nxt     = (state == S_IDLE && accept) ? avs_write : is_wr;
      cyc_active = (state_nxt == S_SETUP) || (state_nxt == S_STROBE) || (state_nxt == S_HOLD);
   end

   // Pin outputs are decoded from the next state so every strobe comes straight from a flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         cnt          <= '0;
         is_wr        <= 1'b0;
         otg_addr     <= '0;
         otg_data_out <= '0;
         otg_data_oe  <= 1'b0;
         otg_cs_n     <= 1'b1;
         otg_rd_n     <= 1'b1;
         otg_wr_n     <= 1'b1;
         avs_readdata <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         is_wr <= wr_nxt;
         if (state == S_IDLE && accept) begin
            otg_addr     <= avs_address;
            otg_data_out <= avs_writedata[15:0];
         end
         otg_cs_n    <= !cyc_active;
         otg_data_oe <= cyc_active && wr_nxt;
         otg_rd_n    <= !(state_nxt == S_STROBE && !wr_nxt);
         otg_wr_n    <= !(state_nxt == S_STROBE && wr_nxt);
         if (state == S_STROBE && cnt_tc && !is_wr)
            avs_readdata <= {16'h0000, otg_data_in};
      end
   end

`ifdef HPI_IRQ_SYNC_EN
   nios_hpi_sync u_irq_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (otg_int),
      .q       (irq)
   );
`endif

endmodule

// File: tb/tb_nios_system_hpi_bus_ctrl.sv
// Self-checking bench for nios_system_hpi_bus_ctrl (default timing; irq test with HPI_IRQ_SYNC_EN).
module tb_nios_system_hpi_bus_ctrl;

   localparam int S     = 1;
   localparam int T     = 4;
   localparam int H     = 1;
   localparam int R     = 2;
   localparam int LAT   = 1 + S + T + H;
   localparam int SPACE = LAT + 1 + R;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  avs_address = '0;
   logic        avs_chipselect = 1'b0;
   logic        avs_read = 1'b0;
   logic        avs_write = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic [31:0] avs_readdata;
   logic        avs_waitrequest;
   logic [1:0]  otg_addr;
   logic [15:0] otg_data_out;
   logic        otg_data_oe;
   logic [15:0] otg_data_in = '0;
   logic        otg_cs_n, otg_rd_n, otg_wr_n;
`ifdef HPI_IRQ_SYNC_EN
   logic        otg_int = 1'b0;
   logic        irq;
`endif

   nios_system_hpi_bus_ctrl dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .avs_address     (avs_address),
      .avs_chipselect  (avs_chipselect),
      .avs_read        (avs_read),
      .avs_write       (avs_write),
      .avs_writedata   (avs_writedata),
      .avs_readdata    (avs_readdata),
      .avs_waitrequest (avs_waitrequest),
      .otg_addr        (otg_addr),
      .otg_data_out    (otg_data_out),
      .otg_data_oe     (otg_data_oe),
      .otg_data_in     (otg_data_in),
      .otg_cs_n        (otg_cs_n),
      .otg_rd_n        (otg_rd_n),
      .otg_wr_n        (otg_wr_n)
`ifdef HPI_IRQ_SYNC_EN
      ,
      .otg_int         (otg_int),
      .irq             (irq)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // Transaction-level model: one active transfer described by its accept cycle.
   bit          m_act = 1'b0;
   int          m_t0 = 0;
   int          m_next_ok = 0;
   bit          m_wr = 1'b0;
   logic [1:0]  m_addr = '0;
   logic [15:0] m_wd = '0;
   logic [31:0] m_rd = '0;
   int          k;
   logic        e_cs, e_rd, e_wr, e_wait, e_oe, strobe;

   int   rd_low_cnt = 0, wr_low_cnt = 0, oe_cnt = 0, done_cnt = 0, done_cyc = 0;
   int   cs_fall_cnt = 0, cs_fall_prev = 0, cs_fall_last = 0;
   logic prev_cs = 1'b1;

   always @(negedge clk) begin
      if (!reset_n) begin
         m_act     = 1'b0;
         m_next_ok = 0;
         m_rd      = '0;
         check("rst_cs_n", {31'b0, otg_cs_n}, 32'd1);
         check("rst_rd_n", {31'b0, otg_rd_n}, 32'd1);
         check("rst_wr_n", {31'b0, otg_wr_n}, 32'd1);
         check("rst_oe", {31'b0, otg_data_oe}, 32'd0);
         check("rst_wait", {31'b0, avs_waitrequest}, 32'd1);
         check("rst_rdata", avs_readdata, 32'd0);
      end else begin
         e_cs   = 1'b1;
         strobe = 1'b0;
         e_wait = 1'b1;
         k      = 0;
         if (m_act) begin
            k      = cyc - m_t0;
            e_cs   = !(k >= 1 && k <= S + T + H);
            strobe = (k >= 1 + S && k <= S + T);
            e_wait = (k != LAT);
         end
         e_wr = !(strobe && m_wr);
         e_rd = !(strobe && !m_wr);
         e_oe = !e_cs && m_wr;
         check("cs_n", {31'b0, otg_cs_n}, {31'b0, e_cs});
         check("rd_n", {31'b0, otg_rd_n}, {31'b0, e_rd});
         check("wr_n", {31'b0, otg_wr_n}, {31'b0, e_wr});
         check("oe", {31'b0, otg_data_oe}, {31'b0, e_oe});
         check("waitrequest", {31'b0, avs_waitrequest}, {31'b0, e_wait});
         check("readdata", avs_readdata, m_rd);
         if (!e_cs) begin
            check("otg_addr", {30'b0, otg_addr}, {30'b0, m_addr});
            if (m_wr) check("otg_data_out", {16'b0, otg_data_out}, {16'b0, m_wd});
         end
         if (m_act && k == S + T && !m_wr) m_rd = {16'h0000, otg_data_in};
         if (cyc >= m_next_ok && avs_chipselect && (avs_read || avs_write)) begin
            m_act     = 1'b1;
            m_t0      = cyc;
            m_wr      = avs_write;
            m_addr    = avs_address;
            m_wd      = avs_writedata[15:0];
            m_next_ok = cyc + SPACE;
         end
      end
      if (!otg_rd_n) rd_low_cnt++;
      if (!otg_wr_n) wr_low_cnt++;
      if (otg_data_oe) oe_cnt++;
      if (!avs_waitrequest) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (prev_cs && !otg_cs_n) begin
         cs_fall_cnt++;
         cs_fall_prev = cs_fall_last;
         cs_fall_last = cyc;
      end
      prev_cs = otg_cs_n;
   end

   task automatic clr_mon();
      rd_low_cnt  = 0;
      wr_low_cnt  = 0;
      oe_cnt      = 0;
      cs_fall_cnt = 0;
   endtask

   task automatic start_req(input bit rd, input bit wr, input logic [1:0] a,
                            input logic [31:0] wd, output int t);
      avs_chipselect = 1'b1;
      avs_read       = rd;
      avs_write      = wr;
      avs_address    = a;
      avs_writedata  = wd;
      t              = cyc;
   endtask

   task automatic wait_done(input string name);
      int d0 = done_cnt;
      bit ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done_cnt != d0) begin
            ok = 1'b1;
            break;
         end
      end
      check(name, {31'b0, ok}, 32'd1);
   endtask

   task automatic go_idle();
      avs_chipselect = 1'b0;
      avs_read       = 1'b0;
      avs_write      = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   int t_a, t_b, d_before;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("init_cs_n", {31'b0, otg_cs_n}, 32'd1);
      check("init_addr", {30'b0, otg_addr}, 32'd0);
      check("init_data_out", {16'b0, otg_data_out}, 32'd0);
      check("init_readdata", avs_readdata, 32'd0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // single write
      clr_mon();
      start_req(1'b0, 1'b1, 2'd2, 32'h1234ABCD, t_a);
      wait_done("wr1_done");
      go_idle();
      check("wr1_latency", done_cyc - t_a, 32'd7);
      check("wr1_cs_fall", cs_fall_last - t_a, 32'd1);
      check("wr1_wr_low", wr_low_cnt, 32'd4);
      check("wr1_rd_low", rd_low_cnt, 32'd0);
      check("wr1_oe_cycles", oe_cnt, 32'd6);

      // single read
      clr_mon();
      otg_data_in = 16'hBEEF;
      start_req(1'b1, 1'b0, 2'd0, 32'h0, t_a);
      wait_done("rd1_done");
      check("rd1_readdata", avs_readdata, 32'h0000BEEF);
      go_idle();
      check("rd1_latency", done_cyc - t_a, 32'd7);
      check("rd1_rd_low", rd_low_cnt, 32'd4);
      check("rd1_wr_low", wr_low_cnt, 32'd0);
      check("rd1_oe", oe_cnt, 32'd0);

      // back-to-back writes; second request presented during RECOVER
      clr_mon();
      start_req(1'b0, 1'b1, 2'd1, 32'h00001111, t_a);
      wait_done("b2b_done1");
      start_req(1'b0, 1'b1, 2'd3, 32'h00002222, t_b);
      wait_done("b2b_done2");
      go_idle();
      check("b2b_spacing", cs_fall_last - cs_fall_prev, 32'd10);
      check("b2b_wr_low", wr_low_cnt, 32'd8);

      // read and write together act as a write
      clr_mon();
      otg_data_in = 16'h5555;
      start_req(1'b1, 1'b1, 2'd1, 32'h0000CAFE, t_a);
      wait_done("rw_done");
      go_idle();
      check("rw_rd_low", rd_low_cnt, 32'd0);
      check("rw_wr_low", wr_low_cnt, 32'd4);
      check("rw_readdata_held", avs_readdata, 32'h0000BEEF);

      // read of STATUS offset is a plain HPI read
      otg_data_in = 16'h1357;
      start_req(1'b1, 1'b0, 2'd3, 32'h0, t_a);
      wait_done("rd2_done");
      go_idle();
      check("rd2_readdata", avs_readdata, 32'h00001357);

      // request dropped after one cycle still completes
      clr_mon();
      d_before = done_cnt;
      start_req(1'b0, 1'b1, 2'd0, 32'h00000F0F, t_a);
      @(posedge clk);
      #1;
      go_idle();
      repeat (8) @(posedge clk);
      #1;
      check("drop_done", done_cnt - d_before, 32'd1);
      check("drop_wr_low", wr_low_cnt, 32'd4);
      check("drop_cs_falls", cs_fall_cnt, 32'd1);

      // reset during the second STROBE cycle
      start_req(1'b0, 1'b1, 2'd2, 32'h00007777, t_a);
      repeat (3) @(posedge clk);
      #2;
      check("pre_rst_wr_n", {31'b0, otg_wr_n}, 32'd0);
      reset_n        = 1'b0;
      avs_chipselect = 1'b0;
      avs_write      = 1'b0;
      #1;
      check("midrst_cs_n", {31'b0, otg_cs_n}, 32'd1);
      check("midrst_wr_n", {31'b0, otg_wr_n}, 32'd1);
      check("midrst_oe", {31'b0, otg_data_oe}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      clr_mon();
      repeat (20) @(posedge clk);
      #1;
      check("postrst_wr_low", wr_low_cnt, 32'd0);
      check("postrst_rd_low", rd_low_cnt, 32'd0);
      check("postrst_cs_falls", cs_fall_cnt, 32'd0);
      check("postrst_wait", {31'b0, avs_waitrequest}, 32'd1);

      // normal transfer after reset
      start_req(1'b0, 1'b1, 2'd1, 32'h0000A5A5, t_a);
      wait_done("postrst_done");
      go_idle();
      check("postrst_latency", done_cyc - t_a, 32'd7);

`ifdef HPI_IRQ_SYNC_EN
      check("irq_low", {31'b0, irq}, 32'd0);
      otg_int = 1'b1;
      @(posedge clk);
      #1;
      check("irq_after_1", {31'b0, irq}, 32'd0);
      @(posedge clk);
      #1;
      check("irq_after_2", {31'b0, irq}, 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
